// File: rtl/freq_div_scheduler.sv
// ============================================================================
// Module      : freq_div_scheduler
// Description : Shares one iterative divider between two result channels of
//               the frequency counter. Requests are arbitrated round-robin,
//               the winner's operands are latched and handed to the divider
//               with a one-cycle start pulse, and the divider result returns
//               to the winning channel as a one-cycle response. A zero
//               divisor is trapped locally and never reaches the divider.
//
// Ports       : clk, rst_n             single clock, synchronous active-low reset
//               reqN_valid/num/den     channel N operand pair (N = 0, 1)
//               reqN_ready             channel N accepted this cycle (comb.)
//               rspN_valid             one-cycle result pulse for channel N
//               rspN_quo/rem/err       channel N result, held until the next
//                                      response to the same channel
//               div_start/num/den      start pulse and latched operands
//               div_quo/rem/done       divider result and completion pulse
//
// Options     : DIV_TIMEOUT_EN         when defined, a WAIT-state watchdog
//                                      ends the operation with err=1,
//                                      quo=0, rem=0 after TIMEOUT_CYCLES
//                                      WAIT cycles without div_done.
//
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module freq_div_scheduler #(
  parameter int WIDTH          = 32,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic             clk,
  input  logic             rst_n,

  input  logic             req0_valid,
  input  logic [WIDTH-1:0] req0_num,
  input  logic [WIDTH-1:0] req0_den,
  output logic             req0_ready,
  output logic             rsp0_valid,
  output logic [WIDTH-1:0] rsp0_quo,
  output logic [WIDTH-1:0] rsp0_rem,
  output logic             rsp0_err,

  input  logic             req1_valid,
  input  logic [WIDTH-1:0] req1_num,
  input  logic [WIDTH-1:0] req1_den,
  output logic             req1_ready,
  output logic             rsp1_valid,
  output logic [WIDTH-1:0] rsp1_quo,
  output logic [WIDTH-1:0] rsp1_rem,
  output logic             rsp1_err,

  output logic             div_start,
  output logic [WIDTH-1:0] div_num,
  output logic [WIDTH-1:0] div_den,
  input  logic [WIDTH-1:0] div_quo,
  input  logic [WIDTH-1:0] div_rem,
  input  logic             div_done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic             rr_q, rr_d;        // channel favoured when both request
  logic             owner_q, owner_d;  // channel of the outstanding operation
  logic [WIDTH-1:0] num_q, num_d;
  logic [WIDTH-1:0] den_q, den_d;

  logic [WIDTH-1:0] rsp0_quo_q, rsp0_quo_d;
  logic [WIDTH-1:0] rsp0_rem_q, rsp0_rem_d;
  logic             rsp0_err_q, rsp0_err_d;
  logic [WIDTH-1:0] rsp1_quo_q, rsp1_quo_d;
  logic [WIDTH-1:0] rsp1_rem_q, rsp1_rem_d;
  logic             rsp1_err_q, rsp1_err_d;

  // Arbitration
  logic             any_valid;
  logic             winner;
  logic             accept;
  logic [WIDTH-1:0] acc_num;
  logic [WIDTH-1:0] acc_den;

  // Result load strobe: asserted on the cycle before RESP so the selected
  // channel's result registers are already valid during the response pulse.
  logic             load;
  logic             load_ch;
  logic [WIDTH-1:0] load_quo;
  logic [WIDTH-1:0] load_rem;
  logic             load_err;

`ifdef DIV_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMO_W-1:0] tmo_q, tmo_d;
`endif

  always_comb begin
    any_valid = req0_valid | req1_valid;
    if (req0_valid && req1_valid) begin
      winner = rr_q;
    end else if (req1_valid) begin
      winner = 1'b1;
    end else begin
      winner = 1'b0;
    end
    accept  = (state_q == IDLE) && any_valid;
    acc_num = winner ? req1_num : req0_num;
    acc_den = winner ? req1_den : req0_den;
  end

  assign req0_ready = accept && !winner;
  assign req1_ready = accept &&  winner;

  // Next-state and datapath
  always_comb begin
    state_d  = state_q;
    rr_d     = rr_q;
    owner_d  = owner_q;
    num_d    = num_q;
    den_d    = den_q;
    load     = 1'b0;
    load_ch  = owner_q;
    load_quo = '0;
    load_rem = '0;
    load_err = 1'b0;
`ifdef DIV_TIMEOUT_EN
    tmo_d    = tmo_q;
`endif

    case (state_q)
      IDLE: begin
        if (accept) begin
          owner_d = winner;
          if (acc_den == '0) begin
            // Divide-by-zero: answer directly, leave the divider operands alone.
            state_d  = RESP;
            load     = 1'b1;
            load_ch  = winner;
            load_quo = '1;
            load_rem = acc_num;
            load_err = 1'b1;
          end else begin
            num_d   = acc_num;
            den_d   = acc_den;
            state_d = ISSUE;
          end
        end
      end

      ISSUE: begin
        state_d = WAIT;
`ifdef DIV_TIMEOUT_EN
        tmo_d   = '0;
`endif
      end

      WAIT: begin
        if (div_done) begin
          state_d  = RESP;
          load     = 1'b1;
          load_quo = div_quo;
          load_rem = div_rem;
          load_err = 1'b0;
        end
`ifdef DIV_TIMEOUT_EN
        // The count is the number of completed WAIT cycles; the cycle in
        // which it equals TIMEOUT_CYCLES-1 is the last one allowed.
        else if (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
          state_d  = RESP;
          load     = 1'b1;
          load_quo = '0;
          load_rem = '0;
          load_err = 1'b1;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
`endif
      end

      RESP: begin
        rr_d    = ~owner_q;
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    rsp0_quo_d = rsp0_quo_q;
    rsp0_rem_d = rsp0_rem_q;
    rsp0_err_d = rsp0_err_q;
    rsp1_quo_d = rsp1_quo_q;
    rsp1_rem_d = rsp1_rem_q;
    rsp1_err_d = rsp1_err_q;
    if (load && !load_ch) begin
      rsp0_quo_d = load_quo;
      rsp0_rem_d = load_rem;
      rsp0_err_d = load_err;
    end
    if (load && load_ch) begin
      rsp1_quo_d = load_quo;
      rsp1_rem_d = load_rem;
      rsp1_err_d = load_err;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      rr_q       <= 1'b0;
      owner_q    <= 1'b0;
      num_q      <= '0;
      den_q      <= '0;
      rsp0_quo_q <= '0;
      rsp0_rem_q <= '0;
      rsp0_err_q <= 1'b0;
      rsp1_quo_q <= '0;
      rsp1_rem_q <= '0;
      rsp1_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      rr_q       <= rr_d;
      owner_q    <= owner_d;
      num_q      <= num_d;
      den_q      <= den_d;
      rsp0_quo_q <= rsp0_quo_d;
      rsp0_rem_q <= rsp0_rem_d;
      rsp0_err_q <= rsp0_err_d;
      rsp1_quo_q <= rsp1_quo_d;
      rsp1_rem_q <= rsp1_rem_d;
      rsp1_err_q <= rsp1_err_d;
    end
  end

`ifdef DIV_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tmo_q <= '0;
    end else begin
      tmo_q <= tmo_d;
    end
  end
`endif

  // Outputs
  assign div_start  = (state_q == ISSUE);
  assign div_num    = num_q;
  assign div_den    = den_q;

  assign rsp0_valid = (state_q == RESP) && !owner_q;
  assign rsp1_valid = (state_q == RESP) &&  owner_q;
  assign rsp0_quo   = rsp0_quo_q;
  assign rsp0_rem   = rsp0_rem_q;
  assign rsp0_err   = rsp0_err_q;
  assign rsp1_quo   = rsp1_quo_q;
  assign rsp1_rem   = rsp1_rem_q;
  assign rsp1_err   = rsp1_err_q;

endmodule

`default_nettype wire

// File: tb/tb_freq_div_scheduler.sv
// ============================================================================
// Module      : tb_freq_div_scheduler
// Description : Self-checking bench for freq_div_scheduler. A behavioural
//               divider answers start pulses after a programmable latency;
//               expected results come from plain arithmetic on the operands
//               the bench itself presented, and the expected winner from a
//               round-robin pointer kept by the bench.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_freq_div_scheduler;

  localparam int W          = 32;
  localparam int TB_TIMEOUT = 64;

  logic         clk;
  logic         rst_n;
  logic         req0_valid, req1_valid;
  logic [W-1:0] req0_num, req0_den, req1_num, req1_den;
  logic         req0_ready, req1_ready;
  logic         rsp0_valid, rsp1_valid;
  logic [W-1:0] rsp0_quo, rsp0_rem, rsp1_quo, rsp1_rem;
  logic         rsp0_err, rsp1_err;
  logic         div_start;
  logic [W-1:0] div_num, div_den;
  logic [W-1:0] div_quo, div_rem;
  logic         div_done;

  int checks = 0;
  int errors = 0;

  bit rr_m;          // expected round-robin pointer
  int div_lat;       // divider model latency in cycles
  bit div_hang;      // divider model never completes
  int stray_cnt;     // bumped by tests to request a stray done pulse

  freq_div_scheduler #(.WIDTH(W), .TIMEOUT_CYCLES(TB_TIMEOUT)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_num   (req0_num),
    .req0_den   (req0_den),
    .req0_ready (req0_ready),
    .rsp0_valid (rsp0_valid),
    .rsp0_quo   (rsp0_quo),
    .rsp0_rem   (rsp0_rem),
    .rsp0_err   (rsp0_err),
    .req1_valid (req1_valid),
    .req1_num   (req1_num),
    .req1_den   (req1_den),
    .req1_ready (req1_ready),
    .rsp1_valid (rsp1_valid),
    .rsp1_quo   (rsp1_quo),
    .rsp1_rem   (rsp1_rem),
    .rsp1_err   (rsp1_err),
    .div_start  (div_start),
    .div_num    (div_num),
    .div_den    (div_den),
    .div_quo    (div_quo),
    .div_rem    (div_rem),
    .div_done   (div_done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Behavioural divider, driven shortly after each rising edge.
  initial begin
    int     cnt;
    bit     busy;
    int     stray_seen;
    logic [W-1:0] m_num, m_den;
    div_done = 1'b0; div_quo = '0; div_rem = '0;
    cnt = 0; busy = 0; stray_seen = 0; m_num = '0; m_den = '1;
    forever begin
      @(posedge clk); #2;
      div_done = 1'b0;
      if (!rst_n) begin
        busy = 0;
      end else if (stray_cnt != stray_seen) begin
        stray_seen = stray_cnt;
        div_done = 1'b1;
        div_quo  = $urandom;
        div_rem  = $urandom;
      end else if (div_start) begin
        busy  = 1;
        cnt   = div_lat;
        m_num = div_num;
        m_den = div_den;
      end else if (busy && !div_hang) begin
        cnt--;
        if (cnt <= 0) begin
          busy     = 0;
          div_done = 1'b1;
          div_quo  = m_num / m_den;
          div_rem  = m_num % m_den;
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Presents nothing itself: the caller has already driven the request(s).
  // Waits for the accept, then follows the operation to its response.
  task automatic serve(input bit ch, input logic [W-1:0] num, input logic [W-1:0] den,
                       input bit immediate);
    int n;
    bit early, extra;
    logic own_v, oth_v, own_err;
    logic [W-1:0] own_quo, own_rem, exp_quo, exp_rem;
    #1;
    n = 0;
    while (!(req0_ready || req1_ready) && n < 100) begin
      @(negedge clk); #1; n++;
    end
    checks++;
    if ((ch ? req1_ready : req0_ready) !== 1'b1 || (ch ? req0_ready : req1_ready) !== 1'b0 ||
        (immediate && n != 0)) begin
      errors++;
      $display("FAIL accept: ready0=%b ready1=%b after %0d cycles, required ready on ch%0d only%s",
               req0_ready, req1_ready, n, ch, immediate ? " immediately" : "");
    end
    @(negedge clk); #1;
    if (ch) req1_valid = 1'b0; else req0_valid = 1'b0;

    if (den == '0) begin
      exp_quo = '1;
      exp_rem = num;
      own_v = ch ? rsp1_valid : rsp0_valid;  oth_v = ch ? rsp0_valid : rsp1_valid;
      own_quo = ch ? rsp1_quo : rsp0_quo;    own_rem = ch ? rsp1_rem : rsp0_rem;
      own_err = ch ? rsp1_err : rsp0_err;
      checks++;
      if (own_v !== 1'b1 || oth_v !== 1'b0 || own_err !== 1'b1 || own_quo !== exp_quo ||
          own_rem !== exp_rem || div_start !== 1'b0) begin
        errors++;
        $display("FAIL divzero ch%0d: valid=%b other=%b err=%b quo=%h rem=%h start=%b, required 1 0 1 %h %h 0",
                 ch, own_v, oth_v, own_err, own_quo, own_rem, div_start, exp_quo, exp_rem);
      end
    end else begin
      exp_quo = num / den;
      exp_rem = num % den;
      checks++;
      if (div_start !== 1'b1 || div_num !== num || div_den !== den ||
          rsp0_valid !== 1'b0 || rsp1_valid !== 1'b0) begin
        errors++;
        $display("FAIL issue ch%0d: start=%b num=%h den=%h rsp=%b%b, required 1 %h %h 00",
                 ch, div_start, div_num, div_den, rsp0_valid, rsp1_valid, num, den);
      end
      n = 0; early = 0; extra = 0;
      do begin
        @(negedge clk); #1; n++;
        if (rsp0_valid || rsp1_valid) early = 1;
        if (div_start) extra = 1;
      end while (!div_done && n < 500);
      checks++;
      if (div_done !== 1'b1 || early || extra) begin
        errors++;
        $display("FAIL wait ch%0d: done=%b early_rsp=%b extra_start=%b, required 1 0 0",
                 ch, div_done, early, extra);
      end
      @(negedge clk); #1;
      own_v = ch ? rsp1_valid : rsp0_valid;  oth_v = ch ? rsp0_valid : rsp1_valid;
      own_quo = ch ? rsp1_quo : rsp0_quo;    own_rem = ch ? rsp1_rem : rsp0_rem;
      own_err = ch ? rsp1_err : rsp0_err;
      checks++;
      if (own_v !== 1'b1 || oth_v !== 1'b0 || own_err !== 1'b0 ||
          own_quo !== exp_quo || own_rem !== exp_rem) begin
        errors++;
        $display("FAIL result ch%0d %h/%h: valid=%b other=%b err=%b quo=%h rem=%h, required 1 0 0 %h %h",
                 ch, num, den, own_v, oth_v, own_err, own_quo, own_rem, exp_quo, exp_rem);
      end
    end
    rr_m = !ch;
    @(negedge clk); #1;
    own_quo = ch ? rsp1_quo : rsp0_quo;
    own_rem = ch ? rsp1_rem : rsp0_rem;
    checks++;
    if (rsp0_valid !== 1'b0 || rsp1_valid !== 1'b0 || own_quo !== exp_quo || own_rem !== exp_rem) begin
      errors++;
      $display("FAIL pulse/hold ch%0d: rsp=%b%b quo=%h rem=%h, required 00 %h %h",
               ch, rsp0_valid, rsp1_valid, own_quo, own_rem, exp_quo, exp_rem);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if ({div_start, div_num, div_den, rsp0_valid, rsp0_quo, rsp0_rem, rsp0_err,
         rsp1_valid, rsp1_quo, rsp1_rem, rsp1_err, req0_ready, req1_ready} !== '0) begin
      errors++;
      $display("FAIL reset: start=%b num=%h den=%h rsp0=%b/%h/%h/%b rsp1=%b/%h/%h/%b, required all zero",
               div_start, div_num, div_den, rsp0_valid, rsp0_quo, rsp0_rem, rsp0_err,
               rsp1_valid, rsp1_quo, rsp1_rem, rsp1_err);
    end
    rst_n = 1'b1;
    rr_m  = 1'b0;
    @(negedge clk); #1;
  endtask

  task automatic test_arbitration();
    div_lat = 5;
    req0_num = 100; req0_den = 10; req1_num = 81; req1_den = 9;
    req0_valid = 1'b1; req1_valid = 1'b1;
    serve(1'b0, 100, 10, 1'b0);
    serve(1'b1, 81, 9, 1'b1);
    req0_num = 200; req0_den = 3; req1_num = 17; req1_den = 4;
    req0_valid = 1'b1; req1_valid = 1'b1;
    serve(1'b0, 200, 3, 1'b0);
    serve(1'b1, 17, 4, 1'b1);
  endtask

  task automatic test_single_ch0();
    div_lat = 34;
    req0_num = 1000; req0_den = 7; req0_valid = 1'b1;
    serve(1'b0, 1000, 7, 1'b0);
  endtask

  task automatic test_div_zero();
    req1_num = 55; req1_den = 0; req1_valid = 1'b1;
    serve(1'b1, 55, 0, 1'b0);
  endtask

  task automatic test_reset_mid_wait();
    int bad;
    div_lat = 30;
    req0_num = 999; req0_den = 4; req0_valid = 1'b1;
    @(negedge clk); #1;
    req0_valid = 1'b0;
    repeat (5) @(negedge clk);
    #1;
    rst_n = 1'b0;
    @(negedge clk); #1;
    rst_n = 1'b1;
    rr_m  = 1'b0;
    checks++;
    if ({div_start, div_num, div_den, rsp0_valid, rsp0_quo, rsp0_rem, rsp0_err,
         rsp1_valid, rsp1_quo, rsp1_rem, rsp1_err} !== '0) begin
      errors++;
      $display("FAIL reset_mid: start=%b num=%h den=%h rsp0=%b/%h/%h/%b rsp1=%b/%h/%h/%b, required all zero",
               div_start, div_num, div_den, rsp0_valid, rsp0_quo, rsp0_rem, rsp0_err,
               rsp1_valid, rsp1_quo, rsp1_rem, rsp1_err);
    end
    bad = 0;
    repeat (40) begin
      @(negedge clk); #1;
      if (rsp0_valid || rsp1_valid || div_start) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL reset_mid_quiet: %0d cycles with rsp/start activity, required 0", bad);
    end
    div_lat = 12;
    req0_num = 12345; req0_den = 11; req0_valid = 1'b1;
    serve(1'b0, 12345, 11, 1'b1);
  endtask

  task automatic test_stray_done_idle();
    int bad;
    stray_cnt++;
    bad = 0;
    repeat (6) begin
      @(negedge clk); #1;
      if (rsp0_valid || rsp1_valid || div_start) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL stray_idle: %0d cycles with rsp/start activity, required 0", bad);
    end
    div_lat = 3;
    req1_num = 77; req1_den = 5; req1_valid = 1'b1;
    serve(1'b1, 77, 5, 1'b1);
  endtask

  task automatic test_random();
    int mode;
    bit w;
    logic [W-1:0] n0, d0, n1, d1;
    repeat (24) begin
      mode = $urandom_range(0, 2);
      n0 = $urandom; n1 = $urandom;
      case ($urandom_range(0, 9))
        0:       d0 = '0;
        1, 2, 3: d0 = $urandom_range(1, 16);
        default: d0 = $urandom;
      endcase
      case ($urandom_range(0, 9))
        0:       d1 = '0;
        1, 2, 3: d1 = $urandom_range(1, 16);
        default: d1 = $urandom;
      endcase
      req0_num = n0; req0_den = d0; req1_num = n1; req1_den = d1;
      div_lat = $urandom_range(1, 40);
      if (mode == 2) begin
        req0_valid = 1'b1; req1_valid = 1'b1;
        w = rr_m;
        serve(w, w ? n1 : n0, w ? d1 : d0, 1'b0);
        div_lat = $urandom_range(1, 40);
        serve(!w, w ? n0 : n1, w ? d0 : d1, 1'b1);
      end else if (mode == 1) begin
        req1_valid = 1'b1;
        serve(1'b1, n1, d1, 1'b0);
      end else begin
        req0_valid = 1'b1;
        serve(1'b0, n0, d0, 1'b0);
      end
    end
  endtask

`ifdef DIV_TIMEOUT_EN
  task automatic test_timeout();
    int n;
    int bad;
    div_hang = 1'b1;
    req0_num = 1234; req0_den = 3; req0_valid = 1'b1;
    @(negedge clk); #1;
    req0_valid = 1'b0;
    checks++;
    if (div_start !== 1'b1) begin
      errors++;
      $display("FAIL timeout_issue: start=%b, required 1", div_start);
    end
    n = 0;
    while (rsp0_valid !== 1'b1 && n < 200) begin
      @(negedge clk); #1; n++;
    end
    checks++;
    if (rsp0_valid !== 1'b1 || n != TB_TIMEOUT + 1 || rsp0_err !== 1'b1 ||
        rsp0_quo !== '0 || rsp0_rem !== '0) begin
      errors++;
      $display("FAIL timeout: valid=%b after %0d cycles err=%b quo=%h rem=%h, required 1 after %0d, 1 0 0",
               rsp0_valid, n, rsp0_err, rsp0_quo, rsp0_rem, TB_TIMEOUT + 1);
    end
    rr_m = 1'b1;
    repeat (5) @(negedge clk);
    #1;
    stray_cnt++;
    bad = 0;
    repeat (8) begin
      @(negedge clk); #1;
      if (rsp0_valid || rsp1_valid) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL late_done: %0d response cycles, required 0", bad);
    end
  endtask
`endif

  initial begin
    rst_n = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_num = '0; req0_den = '0; req1_num = '0; req1_den = '0;
    div_lat = 1; div_hang = 1'b0; stray_cnt = 0; rr_m = 1'b0;

    test_reset();
    test_arbitration();
    test_single_ch0();
    test_div_zero();
    test_reset_mid_wait();
    test_stray_done_idle();
    test_random();
`ifdef DIV_TIMEOUT_EN
    test_timeout();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
